// File: rtl/mem_pkg.sv
// mem_pkg: shared line geometry and FSM/client encodings for the memory arbiter.
package mem_pkg;
  localparam int WORDS_IN_LINE = 8;
  localparam int ADDR_W = 14;
  typedef enum logic [1:0] {IDLE, XFER_I, XFER_D, DONE} arb_state_t;
  typedef enum logic {CL_I, CL_D} client_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbitration of I-cache and D-cache line transfers onto one main-memory port.
module mem_arbiter #(
  parameter int WORDS_IN_LINE = mem_pkg::WORDS_IN_LINE,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  localparam int OFF_W = $clog2(WORDS_IN_LINE),
  localparam int LINE_W = ADDR_W - OFF_W
) (
  input  logic              MEM_CLK,
  input  logic              RST_N,
  input  logic              ic_req,
  input  logic [LINE_W-1:0] ic_line_addr,
  output logic [31:0]       ic_rdata,
  output logic              ic_rvalid,
  output logic [OFF_W-1:0]  ic_word,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [LINE_W-1:0] dc_line_addr,
  input  logic [31:0]       dc_wdata,
  output logic [31:0]       dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_wready,
  output logic [OFF_W-1:0]  dc_word,
  output logic              dc_done,
  output logic              mm_req,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [31:0]       mm_wdata,
  input  logic [31:0]       mm_rdata,
  input  logic              mm_ack
);
  import mem_pkg::*;
  arb_state_t state_q, state_d;
  client_t last_q, last_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic we_q, we_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic in_i, in_d, ack, grant_d;
  assign in_i = state_q == XFER_I;
  assign in_d = state_q == XFER_D;
  assign ack = (in_i | in_d) & mm_ack;
  // last_q doubles as the current owner once a grant is made
  assign grant_d = dc_req & (~ic_req | last_q == CL_I);
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    line_d = line_q;
    we_d = we_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && (ic_req | dc_req)) begin
      state_d = grant_d ? XFER_D : XFER_I;
      last_d = grant_d ? CL_D : CL_I;
      line_d = grant_d ? dc_line_addr : ic_line_addr;
      we_d = grant_d & dc_we;
      cnt_d = '0;
    end else if (ack) begin
      cnt_d = cnt_q + 1'b1;
      state_d = &cnt_q ? DONE : state_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q <= CL_I;
      line_q <= '0;
      we_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      line_q <= line_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
    end
  end
  assign mm_req = in_i | in_d;
  assign mm_we = in_d & we_q;
  assign mm_addr = mm_req ? {line_q, cnt_q} : '0;
  assign mm_wdata = in_d ? dc_wdata : '0;
  assign ic_rvalid = ack & in_i;
  assign ic_rdata = ic_rvalid ? mm_rdata : '0;
  assign ic_word = in_i ? cnt_q : '0;
  assign ic_done = state_q == DONE && last_q == CL_I;
  assign dc_rvalid = ack & in_d & ~we_q;
  assign dc_wready = ack & in_d & we_q;
  assign dc_rdata = dc_rvalid ? mm_rdata : '0;
  assign dc_word = in_d ? cnt_q : '0;
  assign dc_done = state_q == DONE && last_q == CL_D;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter WORDS_IN_LINE, default 8: words per cache line, power of two.
REQ-002 SHALL provide parameter ADDR_W, default 14: main-memory word-address width.
REQ-003 SHALL derive localparam OFF_W = $clog2(WORDS_IN_LINE) and LINE_W = ADDR_W - OFF_W.
REQ-004 Ports (name, direction, width, meaning); one clock; reset is asynchronous and active-low:
- MEM_CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- ic_req  in  1  I-cache line-fill request, level
- ic_line_addr  in  LINE_W  I-cache line address
- ic_rdata  out  32  fill word
- ic_rvalid  out  1  ic_rdata valid, one cycle per word
- ic_word  out  OFF_W  word offset of ic_rdata
- ic_done  out  1  line complete, one-cycle pulse
- dc_req  in  1  D-cache line request, level
- dc_we  in  1  1 = writeback line, 0 = fill line
- dc_line_addr  in  LINE_W  D-cache line address
- dc_wdata  in  32  writeback word for offset dc_word
- dc_rdata  out  32  fill word
- dc_rvalid  out  1  dc_rdata valid, one cycle per word
- dc_wready  out  1  dc_wdata consumed, one cycle per word
- dc_word  out  OFF_W  current word offset
- dc_done  out  1  line complete, one-cycle pulse
- mm_req  out  1  main-memory access request
- mm_we  out  1  main-memory write
- mm_addr  out  ADDR_W  main-memory word address
- mm_wdata  out  32  write data
- mm_rdata  in  32  read data, valid with mm_ack
- mm_ack  in  1  access complete, one-cycle pulse, ≥1 cycle after mm_req rises

Function
REQ-005 FSM states: IDLE, XFER_I, XFER_D, DONE.
REQ-006 IDLE samples ic_req/dc_req; only one requesting -> grant it; neither -> stay IDLE.
REQ-007 Both requesting -> round-robin: grant client not granted last; after reset last-granted = I, so D wins first tie.
REQ-008 On grant, latch line address and dc_we, clear OFF_W word counter, enter XFER_I or XFER_D next cycle.
REQ-009 In XFER_*: mm_req = 1, mm_addr = {latched line addr, counter}, mm_we = latched we (0 for I), mm_wdata = dc_wdata.
REQ-010 On mm_ack in XFER_*: read -> client rdata = mm_rdata, rvalid = 1, word = counter same cycle; write -> dc_wready = 1 same cycle; counter increments.
REQ-011 mm_ack with counter = WORDS_IN_LINE-1 -> go DONE; mm_req low in DONE.
REQ-012 DONE lasts exactly one cycle: granted client's done = 1, then IDLE; client drops req during DONE cycle or it is a new request.
REQ-013 Latched address/we fixed for whole line; req deassertion or address change mid-line ignored; no preemption.
REQ-014 mm_ack outside XFER_* ignored.
REQ-015 Non-granted client rvalid/wready/done remain 0; rdata outputs may mirror mm_rdata.
REQ-016 Counter wraps naturally; no partial-line or burst-length variation.
REQ-017 Client idle-to-grant latency: 1 cycle after req sampled in IDLE; back-to-back lines separated by DONE+IDLE (2 cycles).

Reset
REQ-018 RST_N low asynchronously: state IDLE, counter 0, last-granted = I, all outputs 0.
REQ-019 Reset mid-line aborts transfer; no done pulse; in-flight mm_ack after release ignored.

Structure
REQ-020 Shared package mem_pkg holds WORDS_IN_LINE, ADDR_W, state enum arb_state_t, client enum client_t {CL_I, CL_D}.
REQ-021 Single module; round-robin pointer inline, no sub-module.

Verification
REQ-022 Memory model with 10-cycle ack latency preloaded from otter_mem.mem; ic_req line 0x010 -> 8 rvalid pulses, ic_word 0..7, data = mem[0x080..0x087], one ic_done.
REQ-023 ic_req and dc_req (fill, line 0x300) both rise in same cycle after reset -> D served first, then I; second tie -> I first.
REQ-024 dc_we=1, line 0x301, dc_wdata = word+1 -> mem[0x1808..0x180F] = 1..8, 8 dc_wready pulses, one dc_done; D fill of same line returns 1..8.
REQ-025 Change dc_line_addr and drop dc_req mid-line -> line completes at original address, dc_done still pulses.
REQ-026 Assert RST_N low after 3rd ack -> all outputs 0 immediately; no done; stray ack ignored; next request completes normally.
REQ-027 mm_ack 1 cycle after mm_req (minimum latency) -> full line in 16 cycles, no dropped or duplicated words.
